// File: rtl/seg_pkg.sv
// seg_pkg: shared types, abcdefg hex table and divider helper for the 7-segment scan driver
package seg_pkg;

    typedef enum logic {DEAD, SHOW} phase_e;

    // Segment value for "no segment lit", before the output polarity is applied.
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Active-high abcdefg patterns (bit 6 = a). Index 15 is first in the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1110011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

    function automatic int calc_div(int clk_hz, int refresh_hz, int n);
        return clk_hz / (refresh_hz * n);
    endfunction

endpackage

// File: rtl/seg_scan_driver_hex_to_seg.sv
// hex_to_seg: combinational nibble to active-high abcdefg decoder
//   nib in  [3:0] hex digit
//   seg out [6:0] segments, bit 6 = a ... bit 0 = g
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);
    assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit 7-segment driver with double buffering and dead-time
//   clk, rst          clock and synchronous active-high reset
//   value, dp_in      hex digits (digit 0 = [3:0]) and per-digit decimal points
//   load              strobe capturing value/dp_in into the pending buffer
//   blank_en          level forcing the display dark
//   upd_done          pulse when a new frame value reaches the display register
//   seg, dp, an       registered board pins, polarity set by ACTIVE_LOW
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_HZ      = 100_000_000,
    parameter int REFRESH_HZ  = 1000,
    parameter int DEAD_CYCLES = 64,
    parameter int LZ_BLANK    = 0,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_en,
    output logic                    upd_done,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);
    localparam int   DIV = calc_div(CLK_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam int   CW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int   IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic POL = ACTIVE_LOW != 0;

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, pend_q, pend_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
    logic                    pend_v_q, pend_v_d, upd_done_q, upd_done_d;
    logic [6:0]              seg_q, seg_d, dec;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d, lz;
    logic                    last_slot, boundary, all_zero, lit;
    phase_e                  phase;

    hex_to_seg u_dec (.nib(disp_q[4*idx_q +: 4]), .seg(dec));

    always_comb begin
        last_slot  = cnt_q == CW'(DIV - 1);
        boundary   = last_slot && idx_q == IW'(NUM_DIGITS - 1);
        cnt_d      = last_slot ? '0 : cnt_q + 1'b1;
        idx_d      = !last_slot ? idx_q : boundary ? '0 : idx_q + 1'b1;
        pend_d     = load ? value : pend_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        pend_v_d   = !boundary && (load || pend_v_q);
        // A load on the frame boundary wins over (and discards) any older pending value.
        disp_d     = !boundary ? disp_q : load ? value : pend_v_q ? pend_q : disp_q;
        disp_dp_d  = !boundary ? disp_dp_q : load ? dp_in : pend_v_q ? pend_dp_q : disp_dp_q;
        upd_done_d = boundary && (load || pend_v_q);
        // lz[i] is set when digit i and every digit above it are zero.
        lz       = '0;
        all_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && disp_q[4*i +: 4] == 4'h0;
            lz[i]    = all_zero;
        end
        phase = cnt_q < CW'(DEAD_CYCLES) ? DEAD : SHOW;
        lit   = phase == SHOW && !blank_en && !(LZ_BLANK != 0 && lz[idx_q]);
        seg_d = (lit ? dec : SEG_OFF) ^ {7{POL}};
        dp_d  = (lit && disp_dp_q[idx_q]) ^ POL;
        an_d  = (lit ? NUM_DIGITS'(1) << idx_q : '0) ^ {NUM_DIGITS{POL}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            disp_dp_q  <= '0;
            pend_q     <= '0;
            pend_dp_q  <= '0;
            pend_v_q   <= 1'b0;
            upd_done_q <= 1'b0;
            seg_q      <= {7{POL}};
            dp_q       <= POL;
            an_q       <= {NUM_DIGITS{POL}};
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            pend_q     <= pend_d;
            pend_dp_q  <= pend_dp_d;
            pend_v_q   <= pend_v_d;
            upd_done_q <= upd_done_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign upd_done = upd_done_q;
    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver (DIV=8, 32-clock frame, LZ blanking on)
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_en = 1'b0;
    logic        upd_done;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    seg_scan_driver #(
        .NUM_DIGITS(4), .CLK_HZ(800), .REFRESH_HZ(25),
        .DEAD_CYCLES(2), .LZ_BLANK(1), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
        .blank_en(blank_en), .upd_done(upd_done), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        int         sig;
        logic [7:0] val;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   edges = 0;
    int   checks = 0;
    int   passed = 0;

    localparam int R  = 5;
    localparam int R2 = R + 247;

    always @(posedge clk) edges <= edges + 1;

    task automatic ex(input int at, input int sig, input logic [7:0] v, input string nm);
        exp_t e;
        e.at = at; e.sig = sig; e.val = v; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic ex_an(input int at, input logic [3:0] a, input string nm);
        ex(at, 2, {4'h0, a}, nm);
    endtask

    task automatic ex_show(input int at, input logic [3:0] a, input logic [6:0] s, input string nm);
        ex(at, 2, {4'h0, a}, nm);
        ex(at, 0, {1'b0, s}, nm);
    endtask

    task automatic go(input int e);
        while (edges < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every expectation scheduled for the edge just taken.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at <= edges) begin
            exp_t e;
            logic [7:0] act;
            e = exp_q.pop_front();
            act = e.sig == 0 ? {1'b0, seg} : e.sig == 1 ? {7'h0, dp} :
                  e.sig == 2 ? {4'h0, an} : {7'h0, upd_done};
            checks++;
            if (e.at < edges)
                $display("FAIL %s: expectation for edge %0d missed (now %0d)", e.nm, e.at, edges);
            else if (act !== e.val)
                $display("FAIL %s @edge %0d sig %0d: got %b expected %b", e.nm, edges, e.sig, act, e.val);
            else
                passed++;
        end
    end

    initial begin
        for (int e = 2; e <= 5; e++) begin
            ex(e, 0, 8'h7F, "rst_seg");
            ex(e, 1, 8'h01, "rst_dp");
            ex_an(e, 4'hF, "rst_an");
        end
        ex_an(R + 1, 4'hF, "dead1");
        ex_an(R + 2, 4'hF, "dead2");
        ex_show(R + 3, 4'b1110, 7'b0000001, "first_lit");
        ex(R + 3, 1, 8'h01, "first_dp");
        ex_show(R + 7, 4'b1110, 7'b0000001, "no_tear");
        ex(R + 31, 3, 8'h00, "upd_pre");
        ex(R + 32, 3, 8'h01, "upd_pulse");
        ex(R + 33, 3, 8'h00, "upd_post");
        ex_an(R + 33, 4'hF, "frame_dead");
        ex_show(R + 35, 4'b1110, 7'b0111000, "d0_F");
        ex(R + 35, 1, 8'h01, "d0_dp");
        ex_show(R + 43, 4'b1101, 7'b0001000, "d1_A");
        ex(R + 43, 1, 8'h00, "d1_dp");
        ex_show(R + 51, 4'b1011, 7'b0010010, "d2_2");
        ex_show(R + 59, 4'b0111, 7'b1001111, "d3_1");
        go(R);
        rst = 1'b0;
        go(R + 5);
        value = 16'h12AF; dp_in = 4'b0010; load = 1'b1;
        go(R + 6);
        load = 1'b0;

        ex(R + 96, 3, 8'h01, "lz_upd");
        ex_show(R + 99, 4'b1110, 7'b0000001, "lz_d0");
        ex_show(R + 107, 4'b1101, 7'b1001100, "lz_d1");
        ex_an(R + 115, 4'hF, "lz_d2_start");
        ex_an(R + 120, 4'hF, "lz_d2_end");
        ex_an(R + 123, 4'hF, "lz_d3_start");
        ex(R + 123, 1, 8'h01, "lz_d3_dp");
        ex_an(R + 128, 4'hF, "lz_d3_end");
        go(R + 69);
        value = 16'h0040; dp_in = 4'b1000; load = 1'b1;
        go(R + 70);
        load = 1'b0;

        ex(R + 160, 3, 8'h01, "byp_upd");
        ex(R + 161, 3, 8'h00, "byp_upd_end");
        ex_show(R + 163, 4'b1110, 7'b0100100, "byp_d0");
        ex_show(R + 171, 4'b1101, 7'b0100100, "byp_d1");
        ex_show(R + 179, 4'b1011, 7'b0100100, "byp_d2");
        ex_show(R + 187, 4'b0111, 7'b0100100, "byp_d3");
        ex(R + 192, 3, 8'h00, "stale_no_upd");
        ex_show(R + 195, 4'b1110, 7'b0100100, "stale_gone");
        go(R + 132);
        value = 16'h1111; dp_in = 4'b0000; load = 1'b1;
        go(R + 133);
        load = 1'b0;
        go(R + 159);
        value = 16'h5555; dp_in = 4'b0000; load = 1'b1;
        go(R + 160);
        load = 1'b0;

        ex_an(R + 196, 4'hF, "blank_next");
        ex_an(R + 205, 4'hF, "blank_held");
        ex_show(R + 212, 4'b1011, 7'b0100100, "blank_resume");
        go(R + 195);
        blank_en = 1'b1;
        go(R + 209);
        blank_en = 1'b0;

        ex_show(R + 246, 4'hF, 7'h7F, "mid_rst");
        ex(R + 246, 1, 8'h01, "mid_rst_dp");
        ex_an(R + 247, 4'hF, "mid_rst_hold");
        ex_show(R2 + 3, 4'b1110, 7'b0000001, "post_rst_d0");
        ex_an(R2 + 11, 4'hF, "post_rst_d1");
        ex(R2 + 32, 3, 8'h00, "post_rst_no_upd");
        ex_show(R2 + 35, 4'b1110, 7'b0000001, "post_rst_lost");
        go(R + 230);
        value = 16'h7777; dp_in = 4'b0000; load = 1'b1;
        go(R + 231);
        load = 1'b0;
        go(R + 245);
        rst = 1'b1;
        go(R + 247);
        rst = 1'b0;

        go(R2 + 36);
        for (int t = 0; t < 100 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL timeout: %0d expectations pending, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
